// File: rtl/rca_pkg.sv
// Shared definitions for the sequential nibble-serial adder: slice width, FSM states,
// and the nibble counter width helper.
package rca_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter must be at least one bit wide even for a single-nibble adder.
  function automatic int cnt_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_arb_rca4.sv
// 4-bit ripple-carry adder slice shared by all jobs of the sequential adder.
module rca4
  import rca_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[NIB_W];
  end

endmodule

// File: rtl/rca_seq_arb.sv
// Two-requester wide adder: round-robin arbiter feeding one rca4 slice that is
// stepped across the operands one nibble per cycle, result returned on valid/ready.
module rca_seq_arb
  import rca_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_ci,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_ci,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_co,
  output logic         busy
);

  localparam int               CNT_W = cnt_w(NIBBLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             id_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     result;

  logic             grant;
  logic             accept;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_s;
  logic             nib_co;

  // Round robin: a lone requester always wins; on contention the one not served last.
  always_comb begin
    grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept     = !rst && (state == IDLE) && (req0_valid | req1_valid);
    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Nibble k of the latched operands sits at bit offset 4*k.
  assign nib_a = a_q[{cnt, 2'b00} +: NIB_W];
  assign nib_b = b_q[{cnt, 2'b00} +: NIB_W];

  rca4 U0_rca4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      carry      <= 1'b0;
      id_q       <= 1'b0;
      result     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            id_q       <= grant;
            carry      <= grant ? req1_ci : req0_ci;
            cnt        <= '0;
          end
        end
        ADD: begin
          result[{cnt, 2'b00} +: NIB_W] <= nib_s;
          carry                         <= nib_co;
          cnt                           <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand copies are pure data; they are only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= grant ? req1_a : req0_a;
      b_q <= grant ? req1_b : req0_b;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_s     = result;
  assign rsp_co    = carry;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rca_seq_arb.sv
// Directed plus randomized bench for rca_seq_arb against a job-level reference model.
module tb_rca_seq_arb;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ci, req1_ci;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_co, busy;
  logic [W-1:0] rsp_s;

  rca_seq_arb #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ci    (req0_ci),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ci    (req1_ci),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_co     (rsp_co),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: job phase, cycles spent adding, arbitration memory, pending result.
  int           m_st;
  int           m_cnt;
  logic         m_last;
  logic [W-1:0] m_s;
  logic         m_co;
  logic         m_id;
  bit           m_known;
  bit           acc0, acc1, hold_valid;

  logic         obs_rv, obs_co, obs_id;
  logic [W-1:0] obs_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_last = 1'b1;
    m_s = '0; m_co = 1'b0; m_id = 1'b0; m_known = 1'b1;
  endtask

  task automatic refresh0();
    req0_a = W'($urandom); req0_b = W'($urandom); req0_ci = 1'($urandom);
  endtask

  task automatic refresh1();
    req1_a = W'($urandom); req1_b = W'($urandom); req1_ci = 1'($urandom);
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return after the rising edge.
  task automatic step();
    logic        g, er0, er1;
    logic [W:0]  sum;
    #4;
    g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    er0 = !rst && (m_st == 0) && req0_valid && !g;
    er1 = !rst && (m_st == 0) && req1_valid && g;
    obs_rv = rsp_valid; obs_s = rsp_s; obs_co = rsp_co; obs_id = rsp_id;
    chk("req0_ready", 32'(req0_ready), 32'(er0));
    chk("req1_ready", 32'(req1_ready), 32'(er1));
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_st == 2));
    if (m_st == 2 || m_known) begin
      chk("rsp_s", 32'(rsp_s), 32'(m_s));
      chk("rsp_co", 32'(rsp_co), 32'(m_co));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    acc0 = 1'b0; acc1 = 1'b0;
    if (rst) model_reset();
    else begin
      case (m_st)
        0: if (er0 || er1) begin
             sum = er1 ? ((W+1)'(req1_a) + (W+1)'(req1_b) + (W+1)'(req1_ci))
                       : ((W+1)'(req0_a) + (W+1)'(req0_b) + (W+1)'(req0_ci));
             {m_co, m_s} = sum;
             m_id = g; m_last = g; m_st = 1; m_cnt = 0; m_known = 0;
             acc0 = er0; acc1 = er1;
           end
        1: if (m_cnt == NIBBLES - 1) m_st = 2; else m_cnt++;
        2: if (rsp_ready) m_st = 0;
        default: m_st = 0;
      endcase
    end
    @(posedge clk); #1;
    if (acc0) begin if (hold_valid) refresh0(); else req0_valid = 1'b0; end
    if (acc1) begin if (hold_valid) refresh1(); else req1_valid = 1'b0; end
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (obs_rv) begin k = i; break; end
    end
  endtask

  int           k;
  logic [W-1:0] held_s;

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; hold_valid = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ci = 1'b0;
    req1_a = '0; req1_b = '0; req1_ci = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    model_reset();
    step();
    rst = 1'b0;

    // Single job from requester 0, latency from accept to response.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h4321; req0_ci = 1'b0;
    step();
    wait_rsp(k);
    chk("t1_latency", 32'(k), 32'(NIBBLES + 1));
    chk("t1_sum", 32'(obs_s), 32'h5555);
    chk("t1_co", 32'(obs_co), 32'h0);
    chk("t1_id", 32'(obs_id), 32'h0);

    // Full carry ripple from requester 1.
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_ci = 1'b0;
    step();
    wait_rsp(k);
    chk("t2_latency", 32'(k), 32'(NIBBLES + 1));
    chk("t2_sum", 32'(obs_s), 32'h0000);
    chk("t2_co", 32'(obs_co), 32'h1);
    chk("t2_id", 32'(obs_id), 32'h1);

    // Both requesters always valid: alternating grants at full throughput.
    hold_valid = 1'b1;
    req0_valid = 1'b1; refresh0();
    req1_valid = 1'b1; refresh1();
    for (int j = 0; j < 4; j++) begin
      wait_rsp(k);
      chk("t3_period", 32'(k), 32'(NIBBLES + 2));
      chk("t3_id", 32'(obs_id), 32'(j % 2));
    end

    // Back-pressure on the response port.
    rsp_ready = 1'b0;
    wait_rsp(k);
    held_s = obs_s;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("t4_hold_s", 32'(obs_s), 32'(held_s));
      chk("t4_hold_rv", 32'(obs_rv), 32'h1);
    end
    rsp_ready = 1'b1;
    step();
    hold_valid = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Reset in the middle of an addition.
    req0_valid = 1'b1; refresh0();
    step();
    for (int j = 0; j < 10; j++) begin
      if (m_st == 1 && m_cnt == 2) break;
      step();
    end
    chk("t5_at_cnt2", 32'(m_st == 1 && m_cnt == 2), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("t5_no_rsp", 32'(obs_rv), 32'h0);
    end

    // Operand change after acceptance has no effect.
    req0_valid = 1'b1; req0_a = 16'h0000; req0_b = 16'hFFFF; req0_ci = 1'b1;
    step();
    req0_a = 16'h5A5A;
    wait_rsp(k);
    chk("t6_sum", 32'(obs_s), 32'h0000);
    chk("t6_co", 32'(obs_co), 32'h1);

    // Randomized traffic with occasional resets and back-pressure.
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; refresh0();
        if ($urandom_range(0, 3) == 0) req0_a = 16'hFFFF;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; refresh1();
        if ($urandom_range(0, 3) == 0) req1_b = 16'hFFFF;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 80) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
